complex_mult_pipe: RTL and testbench

//  Pipelined signed complex multiplier p = a*b for the baseband datapath (phase

---
 rtl/complex_mult_pipe_if.sv | 32 +++
 rtl/complex_mult_pipe.sv | 128 ++++++++++++
 tb/tb_complex_mult_pipe.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/complex_mult_pipe_if.sv
// ============================================================================
// Module   : complex_mult_pipe_if
// Brief    : Operand/product bundle for the pipelined complex multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface complex_mult_pipe_if #(
    parameter int IN_W = 16
);
    logic                     enable;
    logic signed [IN_W-1:0]   a_i;
    logic signed [IN_W-1:0]   a_q;
    logic signed [IN_W-1:0]   b_i;
    logic signed [IN_W-1:0]   b_q;
    logic                     input_valid;
    logic signed [2*IN_W-1:0] p_i;
    logic signed [2*IN_W-1:0] p_q;
    logic                     output_valid;

    modport master (
        output enable, a_i, a_q, b_i, b_q, input_valid,
        input  p_i, p_q, output_valid
    );

    modport slave (
        input  enable, a_i, a_q, b_i, b_q, input_valid,
        output p_i, p_q, output_valid
    );
endinterface

`default_nettype wire

// File: rtl/complex_mult_pipe.sv
// ============================================================================
// Module   : complex_mult_pipe
// Brief    : Fixed-latency pipelined signed complex multiplier p = a*b.
// Revision : 1.0
// ============================================================================
`default_nettype none

module complex_mult_pipe #(
    parameter int IN_W    = 16,
    parameter int LATENCY = 4
) (
    input  wire logic          clock,
    input  wire logic          reset,
    complex_mult_pipe_if.slave bus
);

    localparam int c_PW = 2 * IN_W;

    logic signed [IN_W-1:0] r_a_i, r_a_q, r_b_i, r_b_q;
    logic [LATENCY-1:0]     r_vld;
    logic signed [c_PW-1:0] w_pp_ii, w_pp_qq, w_pp_iq, w_pp_qi;
    logic signed [c_PW-1:0] w_s_i, w_s_q;
    logic signed [c_PW-1:0] w_p_i, w_p_q;

    // Stage 1: operand registers, loaded every enabled cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a_i <= '0;
            r_a_q <= '0;
            r_b_i <= '0;
            r_b_q <= '0;
        end else if (bus.enable) begin
            r_a_i <= bus.a_i;
            r_a_q <= bus.a_q;
            r_b_i <= bus.b_i;
            r_b_q <= bus.b_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld <= '0;
        end else if (bus.enable) begin
            r_vld <= {r_vld[LATENCY-2:0], bus.input_valid};
        end
    end

    assign w_pp_ii = c_PW'(r_a_i) * c_PW'(r_b_i);
    assign w_pp_qq = c_PW'(r_a_q) * c_PW'(r_b_q);
    assign w_pp_iq = c_PW'(r_a_i) * c_PW'(r_b_q);
    assign w_pp_qi = c_PW'(r_a_q) * c_PW'(r_b_i);

    // Sums are formed modulo 2^(2*IN_W), identical to a full-precision sum with its MSB dropped.
    if (LATENCY == 2) begin : g_merged
        logic signed [c_PW-1:0] r_s_i, r_s_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_s_i <= '0;
                r_s_q <= '0;
            end else if (bus.enable) begin
                r_s_i <= w_pp_ii - w_pp_qq;
                r_s_q <= w_pp_iq + w_pp_qi;
            end
        end

        assign w_s_i = r_s_i;
        assign w_s_q = r_s_q;
    end else begin : g_split
        logic signed [c_PW-1:0] r_pp_ii, r_pp_qq, r_pp_iq, r_pp_qi;
        logic signed [c_PW-1:0] r_s_i, r_s_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_pp_ii <= '0;
                r_pp_qq <= '0;
                r_pp_iq <= '0;
                r_pp_qi <= '0;
                r_s_i   <= '0;
                r_s_q   <= '0;
            end else if (bus.enable) begin
                r_pp_ii <= w_pp_ii;
                r_pp_qq <= w_pp_qq;
                r_pp_iq <= w_pp_iq;
                r_pp_qi <= w_pp_qi;
                r_s_i   <= r_pp_ii - r_pp_qq;
                r_s_q   <= r_pp_iq + r_pp_qi;
            end
        end

        assign w_s_i = r_s_i;
        assign w_s_q = r_s_q;
    end

    if (LATENCY > 3) begin : g_dly
        logic signed [c_PW-1:0] r_dly_i [LATENCY-3];
        logic signed [c_PW-1:0] r_dly_q [LATENCY-3];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int k = 0; k < LATENCY - 3; k++) begin
                    r_dly_i[k] <= '0;
                    r_dly_q[k] <= '0;
                end
            end else if (bus.enable) begin
                r_dly_i[0] <= w_s_i;
                r_dly_q[0] <= w_s_q;
                for (int k = 1; k < LATENCY - 3; k++) begin
                    r_dly_i[k] <= r_dly_i[k-1];
                    r_dly_q[k] <= r_dly_q[k-1];
                end
            end
        end

        assign w_p_i = r_dly_i[LATENCY-4];
        assign w_p_q = r_dly_q[LATENCY-4];
    end else begin : g_nodly
        assign w_p_i = w_s_i;
        assign w_p_q = w_s_q;
    end

    assign bus.p_i          = w_p_i;
    assign bus.p_q          = w_p_q;
    assign bus.output_valid = r_vld[LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_complex_mult_pipe.sv
// ============================================================================
// Module   : tb_complex_mult_pipe
// Brief    : Randomised self-checking bench for complex_mult_pipe (latency 4 and 2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_complex_mult_pipe;

    localparam int c_IN_W  = 16;
    localparam int c_LAT_A = 4;
    localparam int c_LAT_B = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    complex_mult_pipe_if #(.IN_W(c_IN_W)) bus_a ();
    complex_mult_pipe_if #(.IN_W(c_IN_W)) bus_b ();

    complex_mult_pipe #(.IN_W(c_IN_W), .LATENCY(c_LAT_A)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    complex_mult_pipe #(.IN_W(c_IN_W), .LATENCY(c_LAT_B)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic        v;
        logic [31:0] pi;
        logic [31:0] pq;
    } samp_t;

    // One entry per enabled edge since the last reset: what was presented then.
    samp_t hist[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input int lat, input string nm, input logic ov,
                              input logic [31:0] pi, input logic [31:0] pq);
        logic        e_v;
        logic [31:0] e_pi, e_pq;
        e_v  = 1'b0;
        e_pi = '0;
        e_pq = '0;
        if (hist.size() >= lat) begin
            e_v  = hist[hist.size()-lat].v;
            e_pi = hist[hist.size()-lat].pi;
            e_pq = hist[hist.size()-lat].pq;
        end
        chk({nm, ".valid"}, 64'(ov), 64'(e_v));
        chk({nm, ".p_i"},   64'(pi), 64'(e_pi));
        chk({nm, ".p_q"},   64'(pq), 64'(e_pq));
    endtask

    task automatic drive(input logic en, input logic v,
                         input logic signed [c_IN_W-1:0] ai, input logic signed [c_IN_W-1:0] aq,
                         input logic signed [c_IN_W-1:0] bi, input logic signed [c_IN_W-1:0] bq);
        longint fi, fq;
        samp_t  s;
        bus_a.enable = en; bus_a.input_valid = v;
        bus_a.a_i = ai; bus_a.a_q = aq; bus_a.b_i = bi; bus_a.b_q = bq;
        bus_b.enable = en; bus_b.input_valid = v;
        bus_b.a_i = ai; bus_b.a_q = aq; bus_b.b_i = bi; bus_b.b_q = bq;
        fi = longint'(ai) * longint'(bi) - longint'(aq) * longint'(bq);
        fq = longint'(ai) * longint'(bq) + longint'(aq) * longint'(bi);
        s.v  = v;
        s.pi = fi[31:0];
        s.pq = fq[31:0];
        @(posedge clock);
        if (reset)   hist.delete();
        else if (en) hist.push_back(s);
        #1;
        expect_out(c_LAT_A, "lat4", bus_a.output_valid, bus_a.p_i, bus_a.p_q);
        expect_out(c_LAT_B, "lat2", bus_b.output_valid, bus_b.p_i, bus_b.p_q);
    endtask

    task automatic drive_rand(input logic en, input logic v);
        drive(en, v, c_IN_W'($urandom), c_IN_W'($urandom), c_IN_W'($urandom), c_IN_W'($urandom));
    endtask

    task automatic flush();
        for (int i = 0; i < c_LAT_A + 1; i++) drive_rand(1'b1, 1'b0);
    endtask

    initial begin
        int accepted;
        drive_rand(1'b1, 1'b1);
        drive_rand(1'b0, 1'b1);
        reset = 1'b0;

        drive(1'b1, 1'b1, 16'sd3, 16'sd4, 16'sd1, 16'sd2);
        flush();
        drive(1'b1, 1'b1, 16'sd1000, 16'sd0, 16'sd0, 16'sd2048);
        flush();
        drive(1'b1, 1'b1, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
        flush();
        drive(1'b1, 1'b1, -16'sd7, 16'sd5, 16'sd2, -16'sd3);
        flush();

        // Back-to-back stream with random enable gaps.
        accepted = 0;
        while (accepted < 64) begin
            logic en;
            en = ($urandom_range(0, 3) != 0);
            drive_rand(en, 1'b1);
            if (en) accepted++;
        end
        flush();

        // Reset while three samples are in flight; none may surface afterwards.
        for (int i = 0; i < 3; i++) drive_rand(1'b1, 1'b1);
        reset = 1'b1;
        drive_rand(1'b1, 1'b1);
        reset = 1'b0;
        flush();

        // Reset must win over enable=0.
        for (int i = 0; i < 2; i++) drive_rand(1'b1, 1'b1);
        reset = 1'b1;
        drive_rand(1'b0, 1'b1);
        reset = 1'b0;
        flush();

        // Mixed random valid/enable traffic.
        for (int i = 0; i < 200; i++) drive_rand(1'($urandom_range(0, 3) != 0), 1'($urandom));
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
